// File: rtl/mul_hilo.sv
// Iterative 32x32 unsigned multiplier with HI/LO result registers.
// One shift-add step per clock; HI/LO are written one cycle after the last step.
//
// state | meaning
// IDLE  | waiting for a MULTU command; HI/LO stable
// MUL   | 32 shift-add iterations in progress
// WB    | product complete; HI/LO written and done raised on the next edge
module mul_hilo #(
    parameter logic [5:0] MULTU = 6'b011001,
    parameter logic [5:0] MFHI  = 6'b010000,
    parameter logic [5:0] MFLO  = 6'b010010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    input  logic [5:0]  Signal,
    input  logic        valid,
    output logic        busy,
    output logic        done,
    output logic [31:0] dataOut
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [63:0] r_prod;
    logic [31:0] r_mcand;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [4:0]  r_cnt;
    logic        r_done;
    logic        w_start;
    logic [32:0] w_sum;

    assign w_start = valid && (Signal == MULTU);

    // Carry out of the upper-half add becomes the new product MSB on the shift.
    assign w_sum = r_prod[0] ? ({1'b0, r_prod[63:32]} + {1'b0, r_mcand})
                             : {1'b0, r_prod[63:32]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nxt = MUL;
            MUL:     if (r_cnt == 5'd31) w_state_nxt = WB;
            WB:      w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prod  <= 64'd0;
            r_mcand <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_cnt   <= 5'd0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_mcand <= dataA;
                        r_prod  <= {32'd0, dataB};
                        r_cnt   <= 5'd0;
                    end
                end
                MUL: begin
                    r_prod <= {w_sum, r_prod[31:1]};
                    r_cnt  <= r_cnt + 5'd1;
                end
                WB: begin
                    r_hi   <= r_prod[63:32];
                    r_lo   <= r_prod[31:0];
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;

    always_comb begin
        dataOut = 32'd0;
        if (Signal == MFHI) begin
            dataOut = r_hi;
        end else if (Signal == MFLO) begin
            dataOut = r_lo;
        end
    end

endmodule

// File: doc/mul_hilo.md
MUL_HILO -- requirements
Module: mul_hilo

Interface
REQ-001 The block SHALL have parameter MULTU, default 6'b011001, meaning the Signal code that starts an unsigned multiply.
REQ-002 The block SHALL have parameter MFHI, default 6'b010000, meaning the Signal code that reads HI onto dataOut.
REQ-003 The block SHALL have parameter MFLO, default 6'b010010, meaning the Signal code that reads LO onto dataOut.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port dataA, input, 32 bits: the multiplicand, the same operand bus that feeds the ALU.
REQ-007 The block SHALL have port dataB, input, 32 bits: the multiplier, the same operand bus that feeds the ALU.
REQ-008 The block SHALL have port Signal, input, 6 bits: the funct code, shared with the ALU.
REQ-009 The block SHALL have port valid, input, 1 bit: command strobe qualifying Signal/dataA/dataB this cycle.
REQ-010 The block SHALL have port busy, output, 1 bit: a multiply is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse when HI/LO have just been updated.
REQ-012 The block SHALL have port dataOut, output, 32 bits: HI/LO read data, merged downstream with the ALU result bus.

Function
REQ-013 The block SHALL use states IDLE, MUL and WB, with busy = (state != IDLE) decoded combinationally.
REQ-014 In IDLE, on a rising edge with valid=1 and Signal==MULTU (accept edge E0), the block SHALL:
- latch dataA as the multiplicand;
- load the 64-bit product register with {32'b0, dataB};
- clear the 5-bit iteration counter;
- enter MUL.
REQ-015 In MUL, on each of edges E1..E32 the block SHALL perform one shift-add step:
- if product[0]=1, form the 33-bit sum {carry, sum} = product[63:32] + multiplicand, otherwise {0, product[63:32]};
- load product with {carry, sum, product[31:1]};
- increment the counter.
REQ-016 At E32 (counter == 31) the block SHALL enter WB.
REQ-017 At E33 (WB) the block SHALL write HI = product[63:32] and LO = product[31:0], register done=1 for exactly one cycle, and return to IDLE.
REQ-018 Total latency from E0 to HI/LO visible SHALL be 33 cycles; busy SHALL be high for the 33 cycles following E0.
REQ-019 A valid command arriving while busy=1 SHALL be ignored, with no effect on the operation in flight.
REQ-020 A valid=1 with MULTU in the cycle where done=1 (state is already IDLE) SHALL be accepted as a new E0.
REQ-021 dataOut SHALL be combinational, independent of valid and busy:
- Signal==MFHI -> HI;
- Signal==MFLO -> LO;
- any other code -> 32'b0.
REQ-022 During busy, including the WB cycle, MFHI/MFLO SHALL return the previous HI/LO; the block provides no interlock, and upstream stalls using busy.
REQ-023 Signal codes other than MULTU SHALL not change state, HI, LO or done.
REQ-024 Arithmetic SHALL be unsigned, with the full 64-bit product and no overflow indication.

Reset
REQ-025 While reset=0, asynchronously, the block SHALL force state=IDLE, HI=0, LO=0, product=0, multiplicand=0, counter=0 and done=0; consequently busy=0.
REQ-026 Reset asserted mid-operation SHALL abort the multiply without producing a done pulse; a MULTU accepted after reset deasserts SHALL start cleanly.

Verification
REQ-027 Reset released, then Signal=MFHI and then MFLO -> dataOut=0x00000000 both times; busy=0, done=0.
REQ-028 MULTU with dataA=0xFFFFFFFF, dataB=0xFFFFFFFF -> busy for 33 cycles, then done pulses one cycle, then MFHI=0xFFFFFFFE and MFLO=0x00000001.
REQ-029 MULTU 3x5 -> HI=0, LO=0x0000000F; then MULTU 0x12345678x0 -> HI=0, LO=0.
REQ-030 Start MULTU 0x00010000x0x00010000; at cycle 5 issue MULTU 7x9 with valid=1 -> ignored; result HI=0x00000001, LO=0; MFLO during busy returns the old LO.
REQ-031 Assert reset at iteration 10 of MULTU 0xFFFFFFFFx2 -> busy=0 immediately, HI=LO=0, no done pulse; rerun after release -> HI=1, LO=0xFFFFFFFE.
REQ-032 Back-to-back: second MULTU (2x2) issued in the done cycle of the first -> accepted, busy high again next cycle, final LO=4.
